// File: rtl/dll_ctrl_pkg.sv
// Shared constants and state encoding for the eMMC DLL tap controller.
// Optional feature macro: DLL_TRACK_EN (closed-loop tracking while locked).
package dll_ctrl_pkg;

  localparam int N_TAPS         = 64;
  localparam int TAP_W          = 6;
  localparam int SETTLE_CYC     = 8;
  localparam int SETTLE_CYC_MIN = 3;
  localparam int LOCK_HITS      = 4;
  localparam int OUT_SHIFT      = 2;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_SETTLE = 3'd1;
  localparam state_t S_SAMPLE = 3'd2;
  localparam state_t S_LOCKED = 3'd3;
  localparam state_t S_FAIL   = 3'd4;

endpackage

// File: rtl/dll_tap_decode.sv
// Binary tap index to one-low element select for the master chain.
// Optional feature macro: none.
module dll_tap_decode #(
  parameter int N_TAPS = dll_ctrl_pkg::N_TAPS,
  parameter int TAP_W  = dll_ctrl_pkg::TAP_W
) (
  input  logic [TAP_W-1:0]  tap,
  input  logic              en,
  output logic [N_TAPS-1:0] sel_n
);

  // one element turns the edge around; all high when disabled
  always_comb begin
    sel_n = '1;
    if (en) begin
      for (int i = 0; i < N_TAPS; i++) begin
        if (tap == TAP_W'(i)) sel_n[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dll_tap_ctrl.sv
// Master DLL sweep/lock controller for the eMMC sampling clock path.
// Optional feature macro: DLL_TRACK_EN (keep tracking drift while locked).
module dll_tap_ctrl #(
  parameter int N_TAPS     = dll_ctrl_pkg::N_TAPS,
  parameter int TAP_W      = dll_ctrl_pkg::TAP_W,
  parameter int SETTLE_CYC = dll_ctrl_pkg::SETTLE_CYC,
  parameter int LOCK_HITS  = dll_ctrl_pkg::LOCK_HITS,
  parameter int OUT_SHIFT  = dll_ctrl_pkg::OUT_SHIFT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              phase_early,
  output logic              dll_en,
  output logic [N_TAPS-1:0] sel_n,
  output logic              busy,
  output logic              locked,
  output logic              fail,
  output logic [TAP_W-1:0]  tap_lock,
  output logic [TAP_W-1:0]  tap_out
);

  import dll_ctrl_pkg::*;

  localparam int SET_EFF =
    (SETTLE_CYC < SETTLE_CYC_MIN) ? SETTLE_CYC_MIN : SETTLE_CYC;
  localparam int CNT_W = $clog2(SET_EFF + 1);
  localparam int HIT_W = $clog2(LOCK_HITS + 1);

  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SET_EFF - 1);
  localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(LOCK_HITS - 1);
  localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(N_TAPS - 1);

  state_t           state;
  logic [TAP_W-1:0] tap;
  logic [CNT_W-1:0] settle_cnt;
  logic [HIT_W-1:0] hit_cnt;
  logic             start_q;
  logic [1:0]       sync_q;
  logic             early;
  logic             go;
  logic [TAP_W-1:0] tap_inc;

  assign early   = sync_q[1];
  assign tap_inc = tap + TAP_W'(1);
  assign go      = start_q && (state == S_IDLE ||
                               state == S_LOCKED ||
                               state == S_FAIL);

`ifdef DLL_TRACK_EN
  localparam logic [CNT_W-1:0] TRK_LAST = CNT_W'(SET_EFF);
  logic             trk_dir;
  logic [TAP_W-1:0] tap_dec;
  assign tap_dec = tap - TAP_W'(1);
`endif

  dll_tap_decode #(
    .N_TAPS (N_TAPS),
    .TAP_W  (TAP_W)
  ) u_dec (
    .tap   (tap),
    .en    (dll_en),
    .sel_n (sel_n)
  );

  // sweep/lock state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tap        <= '0;
      settle_cnt <= '0;
      hit_cnt    <= '0;
      start_q    <= 1'b0;
      sync_q     <= 2'b00;
      dll_en     <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      tap_lock   <= '0;
      tap_out    <= '0;
`ifdef DLL_TRACK_EN
      trk_dir    <= 1'b0;
`endif
    end else begin
      start_q <= start;
      sync_q  <= {sync_q[0], phase_early};
      if (go) begin
        state      <= S_SETTLE;
        tap        <= '0;
        settle_cnt <= '0;
        hit_cnt    <= '0;
        dll_en     <= 1'b1;
        busy       <= 1'b1;
        locked     <= 1'b0;
        fail       <= 1'b0;
      end else begin
        case (state)
          S_SETTLE: begin
            if (settle_cnt == SET_LAST) begin
              settle_cnt <= '0;
              state      <= S_SAMPLE;
            end else begin
              settle_cnt <= settle_cnt + CNT_W'(1);
            end
          end
          S_SAMPLE: begin
            if (early) begin
              hit_cnt <= '0;
              if (tap == TAP_MAX) begin
                state  <= S_FAIL;
                busy   <= 1'b0;
                fail   <= 1'b1;
                dll_en <= 1'b0;
              end else begin
                tap   <= tap_inc;
                state <= S_SETTLE;
              end
            end else if (hit_cnt == HIT_LAST) begin
              hit_cnt  <= '0;
              state    <= S_LOCKED;
              busy     <= 1'b0;
              locked   <= 1'b1;
              tap_lock <= tap;
              tap_out  <= tap >> OUT_SHIFT;
`ifdef DLL_TRACK_EN
              trk_dir  <= 1'b0;
`endif
            end else begin
              hit_cnt <= hit_cnt + HIT_W'(1);
              state   <= S_SETTLE;
            end
          end
          S_LOCKED: begin
`ifdef DLL_TRACK_EN
            if (settle_cnt == TRK_LAST) begin
              settle_cnt <= '0;
              if (early != trk_dir) begin
                trk_dir <= early;
                hit_cnt <= HIT_W'(1);
              end else if (hit_cnt == HIT_LAST) begin
                hit_cnt <= '0;
                if (early && tap != TAP_MAX) begin
                  tap      <= tap_inc;
                  tap_lock <= tap_inc;
                  tap_out  <= tap_inc >> OUT_SHIFT;
                end else if (!early && tap != '0) begin
                  tap      <= tap_dec;
                  tap_lock <= tap_dec;
                  tap_out  <= tap_dec >> OUT_SHIFT;
                end
              end else begin
                hit_cnt <= hit_cnt + HIT_W'(1);
              end
            end else begin
              settle_cnt <= settle_cnt + CNT_W'(1);
            end
`endif
          end
          S_IDLE, S_FAIL: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dll_tap_ctrl.sv
// Scoreboard bench for dll_tap_ctrl against a delay-line phase model.
// Optional feature macro: DLL_TRACK_EN (enables the drift tracking checks).
module tb_dll_tap_ctrl;

  localparam int NT = 64;
  localparam int TW = 6;
  localparam int SC = 8;
  localparam int LH = 4;
  localparam int OS = 2;
  localparam int EV = SC + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          phase_early = 1'b0;
  logic          dll_en, busy, locked, fail;
  logic [NT-1:0] sel_n;
  logic [TW-1:0] tap_lock, tap_out;

  dll_tap_ctrl #(
    .N_TAPS(NT), .TAP_W(TW), .SETTLE_CYC(SC),
    .LOCK_HITS(LH), .OUT_SHIFT(OS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .phase_early(phase_early), .dll_en(dll_en),
    .sel_n(sel_n), .busy(busy), .locked(locked),
    .fail(fail), .tap_lock(tap_lock), .tap_out(tap_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int hold_tap = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // delay-line environment: early below a threshold tap,
  // optional glitch tap that reads late for its first few samples
  int thr = NT;
  int g_tap = -1;
  int g_n = 0;
  int force_v = -1;
  bit rnd_mode = 1'b0;

  function automatic bit early_fn(int t, int idx);
    if (force_v >= 0) return force_v[0];
    if (t == g_tap && idx < g_n) return 1'b0;
    return t < thr;
  endfunction

  int cot = 0;
  logic [NT-1:0] prev_sel = '1;

  always @(negedge clk) begin
    int t;
    t = -1;
    for (int i = 0; i < NT; i++) if (!sel_n[i]) t = i;
    if (sel_n != prev_sel) cot = 0;
    else cot++;
    prev_sel = sel_n;
    if (rnd_mode) phase_early = 1'($urandom_range(0, 1));
    else phase_early = early_fn(t, cot / EV);
  end

  typedef struct {
    bit is_fail;
    int cyc;
    int tap;
  } ev_t;

  ev_t exp_q[$];
  int  ev_done = 0;

  // reference: walk taps, count evaluations, apply lock/fail rules
  function automatic ev_t model();
    ev_t e;
    int evals;
    evals = 0;
    for (int t = 0; t < NT; t++) begin
      int hits;
      int idx;
      bit nxt;
      hits = 0;
      idx = 0;
      nxt = 1'b0;
      while (!nxt) begin
        evals++;
        if (early_fn(t, idx)) begin
          nxt = 1'b1;
        end else begin
          hits++;
          if (hits == LH) begin
            e.is_fail = 1'b0;
            e.tap = t;
            e.cyc = evals * EV + 1;
            return e;
          end
        end
        idx++;
      end
    end
    e.is_fail = 1'b1;
    e.tap = 0;
    e.cyc = NT * EV + 1;
    return e;
  endfunction

  // monitor: pops an expectation on every locked/fail rise
  logic pl = 1'b0;
  logic pf = 1'b0;

  always @(negedge clk) begin
    ev_t e;
    if (rst_n && ((locked && !pl) || (fail && !pf))) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_evt", 64'({locked, fail}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("evt_kind", 64'(fail), 64'(e.is_fail));
        chk("evt_cycle", 64'(cyc), 64'(e.cyc));
        chk("evt_busy", 64'(busy), 64'd0);
        if (e.is_fail) begin
          chk("fail_dll_en", 64'(dll_en), 64'd0);
          chk("fail_locked", 64'(locked), 64'd0);
          chk("fail_sel_n", sel_n, '1);
          chk("fail_hold", 64'(tap_lock), 64'(hold_tap));
        end else begin
          chk("tap_lock", 64'(tap_lock), 64'(e.tap));
          chk("tap_out", 64'(tap_out), 64'(e.tap >> OS));
          chk("lock_sel_n", sel_n, ~(64'd1 << e.tap));
          chk("lock_dll_en", 64'(dll_en), 64'd1);
        end
      end
      ev_done++;
    end
    pl = locked;
    pf = fail;
  end

  task automatic run(int thr_i, int gt, int gn, int fv,
                     bit mid, bit rchk);
    ev_t e;
    int c0;
    int tgt;
    int n;
    thr = thr_i;
    g_tap = gt;
    g_n = gn;
    force_v = fv;
    e = model();
    tgt = ev_done + 1;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc + 1;
    e.cyc += c0;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (rchk) begin
      chk("restart_hold", 64'(locked), 64'd1);
      @(negedge clk);
      chk("restart_drop", 64'(locked), 64'd0);
      chk("restart_busy", 64'(busy), 64'd1);
      chk("restart_sel", sel_n, ~64'd1);
    end
    if (mid) begin
      repeat (15) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (ev_done < tgt && n < NT * EV + 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (ev_done < tgt) begin
      total++;
      bad++;
      $display("FAIL evt_timeout: none after %0d cycles, want cycle %0d",
               n, e.cyc);
      exp_q.delete();
    end else if (!e.is_fail) begin
      hold_tap = e.tap;
    end
  endtask

  initial begin
    int rt, gt;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("rst_flags", 64'({dll_en, busy, locked, fail}), 64'd0);
      chk("rst_taps", 64'({tap_lock, tap_out}), 64'd0);
      chk("rst_sel_n", sel_n, '1);
    end

    run(10, -1, 0, -1, 1'b0, 1'b0);
    run(10, -1, 0, -1, 1'b1, 1'b1);

`ifdef DLL_TRACK_EN
    force_v = 1;
    for (int i = 0; i < 80 && tap_lock == 6'd10; i++) @(negedge clk);
    chk("trk_up", 64'(tap_lock), 64'd11);
    chk("trk_up_out", 64'(tap_out), 64'd2);
    force_v = 0;
    for (int i = 0; i < 80 && tap_lock == 6'd11; i++) @(negedge clk);
    chk("trk_down", 64'(tap_lock), 64'd10);
    repeat (4) begin
      force_v = 1;
      repeat (3 * EV) @(negedge clk);
      force_v = 0;
      repeat (EV) @(negedge clk);
    end
    chk("trk_mixed", 64'(tap_lock), 64'd10);
    chk("trk_locked", 64'(locked), 64'd1);
    chk("trk_sel_n", sel_n, ~(64'd1 << 10));
    hold_tap = 10;
`else
    rnd_mode = 1'b1;
    repeat (80) @(negedge clk);
    rnd_mode = 1'b0;
    chk("frozen_tap", 64'(tap_lock), 64'(hold_tap));
    chk("frozen_sel", sel_n, ~(64'd1 << hold_tap));
    chk("frozen_lock", 64'(locked), 64'd1);
`endif

    run(0, -1, 0, 1, 1'b0, 1'b0);
    run(8, 5, 2, -1, 1'b1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      rt = $urandom_range(0, 20);
      gt = (rt > 0) ? $urandom_range(0, rt - 1) : -1;
      run(rt, gt, $urandom_range(0, LH - 1), -1,
          1'($urandom_range(0, 1)), 1'b0);
    end

    thr = 30;
    g_tap = -1;
    force_v = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", 64'({dll_en, busy, locked, fail}), 64'd0);
    chk("midrst_taps", 64'({tap_lock, tap_out}), 64'd0);
    chk("midrst_sel", sel_n, '1);
    exp_q.delete();
    hold_tap = 0;
    @(negedge clk);
    rst_n = 1'b1;

    run(int'($urandom_range(0, 20)), -1, 0, -1, 1'b0, 1'b0);
    run(0, -1, 0, 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dll_tap_ctrl.md
# dll_tap_ctrl

Lock controller for the eMMC sampling-clock DLL. Sweeps the master delay chain by selecting one turnaround element at a time, confirms lock against a phase detector, and publishes the locked tap plus a scaled tap code for the slave (sample-point) chain. Sits between the AHB-side configuration registers and the delay-element chains in the eMMC host clock path.

## Interface
Parameters:
- N_TAPS, 64, number of delay elements in the master chain
- TAP_W, 6, tap index width, covering N_TAPS-1
- SETTLE_CYC, 8, wait cycles after a tap change before sampling; minimum 3
- LOCK_HITS, 4, consecutive matching samples required to lock or to step in tracking
- OUT_SHIFT, 2, right shift from tap_lock to tap_out; 2 gives a quarter period

Ports (one clock; reset is asynchronous and active-low):
- clk, in, 1, controller clock (card reference clock domain)
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, one-cycle pulse that starts calibration
- phase_early, in, 1, phase detector output, asynchronous; 1 means the delayed edge precedes the reference edge
- dll_en, out, 1, master chain enable (`en` of every element)
- sel_n, out, N_TAPS, per-element select; exactly one bit low while dll_en is high, that bit is the turnaround element
- busy, out, 1, sweep in progress
- locked, out, 1, lock achieved and outputs valid
- fail, out, 1, sweep exhausted without lock
- tap_lock, out, TAP_W, locked master tap index
- tap_out, out, TAP_W, tap_lock >> OUT_SHIFT, code for the slave chain

## Operation
- phase_early passes through a 2-flop synchronizer before any use.
- States are IDLE, SETTLE, SAMPLE, LOCKED and FAIL.
- IDLE: start moves to SETTLE with tap=0, hit_cnt=0, busy=1, dll_en=1, fail=0 and locked=0.
- SETTLE: counts SETTLE_CYC cycles, then moves to SAMPLE.
- SAMPLE, synced early=1: hit_cnt=0.
  - If tap=N_TAPS-1, go to FAIL.
  - Otherwise tap+1 and go to SETTLE.
- SAMPLE, synced early=0: hit_cnt+1.
  - If hit_cnt reaches LOCK_HITS, go to LOCKED with tap_lock=tap.
  - Otherwise go back to SETTLE on the same tap.
- LOCKED: busy=0, locked=1, sel_n selects tap_lock, tap_out=tap_lock>>OUT_SHIFT.
- FAIL: busy=0, fail=1, dll_en=0, sel_n all ones; tap_lock and tap_out hold their previous values.
- start in SETTLE or SAMPLE is ignored.
- start in LOCKED or FAIL restarts from the IDLE→SETTLE transition; locked and fail drop on the next cycle.
- sel_n is decoded from the registered tap: all ones except bit[tap]=0 while dll_en=1, all ones otherwise.

## Timing
- Reset values: dll_en=0, sel_n all ones, busy=0, locked=0, fail=0, tap_lock=0, tap_out=0, state=IDLE.
- start is sampled at edge 0. busy, dll_en and sel_n (tap 0) are valid after edge 1.
- One evaluation lasts SETTLE_CYC+1 cycles, because sel_n changes at SETTLE entry.
- Lock at tap k: locked rises (k+LOCK_HITS)·(SETTLE_CYC+1)+1 cycles after start.
- Fail: fail rises N_TAPS·(SETTLE_CYC+1)+1 cycles after start when the input is always early.
- All outputs are registered, with no combinational path from inputs.
- Reset mid-sweep returns every output to its reset value immediately.

## Configuration
- DLL_TRACK_EN defined: in LOCKED the controller keeps evaluating every SETTLE_CYC+1 cycles.
  - LOCK_HITS consecutive early samples: tap_lock+1, saturating at N_TAPS-1.
  - LOCK_HITS consecutive late samples: tap_lock−1, saturating at 0.
  - A sample of the opposite sense clears the counter.
  - sel_n and tap_out follow on the next cycle; locked stays 1.
- DLL_TRACK_EN undefined: tap_lock is frozen in LOCKED and phase_early is ignored until the next start.

## Structure
- Package dll_ctrl_pkg holds the state enum and default parameter constants (N_TAPS, TAP_W, SETTLE_CYC_MIN).
- Sub-module dll_tap_decode (TAP_W binary plus enable to N_TAPS one-low sel_n) is instantiated once.
- The 2-flop synchronizer is inline.

## Test plan
- Reset, no start: all outputs at reset values for 100 cycles. sel_n=64'hFFFF_FFFF_FFFF_FFFF.
- Detector model late from tap 10 up, defaults: locked rises at cycle (10+4)·9+1=127, tap_lock=10, tap_out=2, sel_n bit10 low only.
- phase_early held 1: fail at cycle 64·9+1=577, dll_en=0, locked=0.
- Glitch: late at tap 5 for 2 samples, then early. No lock at 5; lock at the next stable-late tap.
- start during sweep is ignored. start in LOCKED: locked drops in 1 cycle and tap restarts at 0.
- DLL_TRACK_EN with drift injected after lock: 4 early samples move tap_lock 10→11; 4 late samples move it back; a mixed pattern causes no step.
